id_stage_decoder: RTL

//  Next-generation RV32I/RV64I decode stage for the pipelined core: full-instruction decode (opcode+funct3+funct7),

---
 rtl/id_stage_decoder_if.sv | 48 ++++
 rtl/id_stage_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_decoder_if.sv
// Handshake and decoded-bundle signals between IF/ID, the decode stage and execute.
// No logic; the decoder takes the slave view, the surrounding pipeline the master view.
// Widths follow XLEN and the bubble counter width.
interface id_stage_decoder_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_pc;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_immtype;
    logic [4:0]       out_alu_ctrl;
    logic [2:0]       out_funct3;
    logic             out_regwrite;
    logic             out_alusrc;
    logic             out_pctoregsrc;
    logic             out_rdsrc;
    logic             out_memread;
    logic             out_memwrite;
    logic             out_memtoreg;
    logic [1:0]       out_isbj;
    logic             out_illegal;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_immtype,
               out_alu_ctrl, out_funct3, out_regwrite, out_alusrc, out_pctoregsrc, out_rdsrc,
               out_memread, out_memwrite, out_memtoreg, out_isbj, out_illegal, bubble_cnt
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_immtype,
               out_alu_ctrl, out_funct3, out_regwrite, out_alusrc, out_pctoregsrc, out_rdsrc,
               out_memread, out_memwrite, out_memtoreg, out_isbj, out_illegal, bubble_cnt
    );
endinterface

// File: rtl/id_stage_decoder.sv
// RV32I/RV64I decode stage: full decode, immediates, illegal detection, load-use bubbles, ID/EX register.
// Latency 1 cycle from accept edge to out_*.
// Backpressure: in_ready = (out_ready | ~out_valid) & ~load_use & ~flush; otherwise ID/EX holds.
module id_stage_decoder #(
    parameter int XLEN  = 32,
    parameter bit EN_M  = 1'b0,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    id_stage_decoder_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;

    localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10, ALU_MUL = 5'd16;

    localparam logic [1:0] BJ_B = 2'b00, BJ_J = 2'b01, BJ_JR = 2'b10, BJ_NONE = 2'b11;

    // Shared funct3 -> ALU op map for OP and OP-IMM; alt selects SUB (when allowed) / SRA.
    function automatic logic [4:0] alu_base(input logic [2:0] f, input logic alt, input logic sub_ok);
        logic [4:0] r;
        case (f)
            3'b000:  r = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        shamt_hi_bad;

    assign inst         = bus.in_inst;
    assign opcode       = inst[6:0];
    assign f3           = inst[14:12];
    assign f7           = inst[31:25];
    // shamt[5] only exists on RV64
    assign shamt_hi_bad = (XLEN == 32) && inst[25];

    logic        d_regwrite, d_alusrc, d_pctoregsrc, d_rdsrc;
    logic        d_memread, d_memwrite, d_memtoreg, d_illegal;
    logic [1:0]  d_isbj;
    logic [2:0]  d_immtype;
    logic [4:0]  d_alu;
    logic        uses_rs1, uses_rs2, known, bad;

    // Opcode/funct decode into control bits plus legality; illegal words are made harmless.
    always_comb begin
        d_regwrite   = 1'b0;
        d_alusrc     = 1'b0;
        d_pctoregsrc = 1'b0;
        d_rdsrc      = 1'b0;
        d_memread    = 1'b0;
        d_memwrite   = 1'b0;
        d_memtoreg   = 1'b0;
        d_isbj       = BJ_NONE;
        d_immtype    = IMM_R;
        d_alu        = ALU_ADD;
        uses_rs1     = 1'b0;
        uses_rs2     = 1'b0;
        known        = 1'b1;
        bad          = 1'b0;
        case (opcode)
            OPC_OP: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_memtoreg = 1'b1;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                if (f7 == 7'b0000001) begin
                    bad   = !EN_M;
                    d_alu = ALU_MUL | {2'b00, f3};
                end else begin
                    bad   = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                    d_alu = alu_base(f3, f7[5], 1'b1);
                end
            end
            OPC_OPIMM: begin
                d_regwrite = 1'b1;
                d_memtoreg = 1'b1;
                d_immtype  = IMM_I;
                uses_rs1   = 1'b1;
                d_alu      = alu_base(f3, inst[30], 1'b0);
                if (f3 == 3'b001)
                    bad = (inst[31:26] != 6'b000000) || shamt_hi_bad;
                else if (f3 == 3'b101)
                    bad = ((inst[31:26] != 6'b000000) && (inst[31:26] != 6'b010000)) || shamt_hi_bad;
            end
            OPC_LOAD: begin
                d_regwrite = 1'b1;
                d_memread  = 1'b1;
                d_immtype  = IMM_I;
                uses_rs1   = 1'b1;
                bad        = (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
            end
            OPC_STORE: begin
                d_memwrite = 1'b1;
                d_memtoreg = 1'b1;
                d_immtype  = IMM_S;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                bad        = (f3 > 3'b011) || ((XLEN == 32) && (f3 == 3'b011));
            end
            OPC_BRANCH: begin
                d_alusrc     = 1'b1;
                d_pctoregsrc = 1'b1;
                d_memtoreg   = 1'b1;
                d_isbj       = BJ_B;
                d_immtype    = IMM_B;
                d_alu        = ALU_SUB;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                bad          = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_JAL: begin
                d_regwrite = 1'b1;
                d_rdsrc    = 1'b1;
                d_memtoreg = 1'b1;
                d_isbj     = BJ_J;
                d_immtype  = IMM_J;
            end
            OPC_JALR: begin
                d_regwrite = 1'b1;
                d_rdsrc    = 1'b1;
                d_memtoreg = 1'b1;
                d_isbj     = BJ_JR;
                d_immtype  = IMM_I;
                uses_rs1   = 1'b1;
                bad        = (f3 != 3'b000);
            end
            OPC_AUIPC: begin
                d_regwrite   = 1'b1;
                d_pctoregsrc = 1'b1;
                d_rdsrc      = 1'b1;
                d_memtoreg   = 1'b1;
                d_immtype    = IMM_U;
            end
            OPC_LUI: begin
                d_regwrite   = 1'b1;
                d_pctoregsrc = 1'b1;
                d_memtoreg   = 1'b1;
                d_immtype    = IMM_U;
                d_alu        = ALU_PASSB;
            end
            default: known = 1'b0;
        endcase
        d_illegal = (inst[1:0] != 2'b11) || !known || bad;
        if (d_illegal) begin
            d_regwrite = 1'b0;
            d_memread  = 1'b0;
            d_memwrite = 1'b0;
            d_isbj     = BJ_NONE;
        end
    end

    logic signed [31:0] imm32;
    logic [XLEN-1:0]    d_imm;
    logic [4:0]         d_rs1, d_rs2, d_rd;

    // Immediate assembly per format and unused-index zeroing.
    always_comb begin
        case (d_immtype)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        d_imm = XLEN'(imm32);
        d_rs1 = ((d_immtype == IMM_U) || (d_immtype == IMM_J)) ? 5'd0 : inst[19:15];
        d_rs2 = ((d_immtype == IMM_I) || (d_immtype == IMM_U) || (d_immtype == IMM_J)) ? 5'd0 : inst[24:20];
        d_rd  = ((d_immtype == IMM_S) || (d_immtype == IMM_B)) ? 5'd0 : inst[11:7];
    end

    logic adv, load_use;

    assign adv      = bus.out_ready || !bus.out_valid;
    assign load_use = bus.out_valid && bus.out_memread && (bus.out_rd != 5'd0) &&
                      ((uses_rs1 && (inst[19:15] == bus.out_rd)) ||
                       (uses_rs2 && (inst[24:20] == bus.out_rd)));
    assign bus.in_ready = adv && !load_use && !bus.flush;

    // ID/EX register: flush beats bubble beats advance; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_pc         <= '0;
            bus.out_rs1        <= '0;
            bus.out_rs2        <= '0;
            bus.out_rd         <= '0;
            bus.out_imm        <= '0;
            bus.out_immtype    <= IMM_R;
            bus.out_alu_ctrl   <= ALU_ADD;
            bus.out_funct3     <= '0;
            bus.out_regwrite   <= 1'b0;
            bus.out_alusrc     <= 1'b0;
            bus.out_pctoregsrc <= 1'b0;
            bus.out_rdsrc      <= 1'b0;
            bus.out_memread    <= 1'b0;
            bus.out_memwrite   <= 1'b0;
            bus.out_memtoreg   <= 1'b0;
            bus.out_isbj       <= BJ_NONE;
            bus.out_illegal    <= 1'b0;
            bus.bubble_cnt     <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (adv && load_use && bus.in_valid) begin
            bus.out_valid <= 1'b0;
            if (bus.bubble_cnt != {CNT_W{1'b1}})
                bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
        end else if (adv) begin
            bus.out_valid      <= bus.in_valid;
            bus.out_pc         <= bus.in_pc;
            bus.out_rs1        <= d_rs1;
            bus.out_rs2        <= d_rs2;
            bus.out_rd         <= d_rd;
            bus.out_imm        <= d_imm;
            bus.out_immtype    <= d_immtype;
            bus.out_alu_ctrl   <= d_alu;
            bus.out_funct3     <= f3;
            bus.out_regwrite   <= d_regwrite;
            bus.out_alusrc     <= d_alusrc;
            bus.out_pctoregsrc <= d_pctoregsrc;
            bus.out_rdsrc      <= d_rdsrc;
            bus.out_memread    <= d_memread;
            bus.out_memwrite   <= d_memwrite;
            bus.out_memtoreg   <= d_memtoreg;
            bus.out_isbj       <= d_isbj;
            bus.out_illegal    <= d_illegal;
        end
    end
endmodule
